// File: rtl/accel_stage_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// =====================================================================
// accel_stage_sequencer_if: start/abort request and stage-control bundle
// Rev 1.0
// =====================================================================
interface accel_stage_sequencer_if #(
  parameter int NUM_STAGES = 4,
  parameter int IDX_W      = $clog2(NUM_STAGES > 1 ? NUM_STAGES : 2)
) ();

  logic                  start;
  logic                  abort;
  logic [NUM_STAGES-1:0] stage_en;
  logic [NUM_STAGES-1:0] stage_pulse;
  logic [IDX_W-1:0]      stage_idx;
  logic                  busy;
  logic                  done;

  modport master (
    output start,
    output abort,
    input  stage_en,
    input  stage_pulse,
    input  stage_idx,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  abort,
    output stage_en,
    output stage_pulse,
    output stage_idx,
    output busy,
    output done
  );

endinterface
`default_nettype wire

// File: rtl/accel_stage_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// =====================================================================
// accel_stage_sequencer: walks NUM_STAGES stage enables, STAGE_CYCLES each
// Rev 1.0
// =====================================================================
module accel_stage_sequencer #(
  parameter int NUM_STAGES   = 4,
  parameter int STAGE_CYCLES = 1,
  parameter bit CUMULATIVE   = 1'b1,
  parameter int IDX_W        = $clog2(NUM_STAGES > 1 ? NUM_STAGES : 2)
) (
  input  wire logic              clk,
  input  wire logic              reset_n,
  accel_stage_sequencer_if.slave ctl
);

  localparam int DWELL_W = $clog2(STAGE_CYCLES + 1);

  localparam logic [DWELL_W-1:0] c_dwell_last = DWELL_W'(STAGE_CYCLES - 1);
  localparam logic [IDX_W-1:0]   c_idx_last   = IDX_W'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] c_stage0  = NUM_STAGES'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DWELL_W-1:0]    dwell_q, dwell_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_STAGES-1:0] stage_en_q, stage_en_d;
  logic [NUM_STAGES-1:0] stage_pulse_q, stage_pulse_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [IDX_W-1:0]      w_idx_inc;
  logic [NUM_STAGES-1:0] w_next_onehot;
  logic [NUM_STAGES-1:0] w_adv_en;
  logic [NUM_STAGES-1:0] w_done_en;

  assign w_idx_inc     = idx_q + IDX_W'(1);
  assign w_next_onehot = c_stage0 << w_idx_inc;

  // Enable pattern on a stage advance and while parked in DONE
  if (CUMULATIVE) begin : g_en_cumulative
    assign w_adv_en  = stage_en_q | w_next_onehot;
    assign w_done_en = '1;
  end else begin : g_en_onehot
    assign w_adv_en  = w_next_onehot;
    assign w_done_en = '0;
  end

  always_comb begin
    state_d       = state_q;
    dwell_d       = dwell_q;
    idx_d         = idx_q;
    stage_en_d    = stage_en_q;
    stage_pulse_d = '0;
    busy_d        = busy_q;
    done_d        = done_q;

    if (ctl.abort) begin
      state_d    = S_IDLE;
      dwell_d    = '0;
      idx_d      = '0;
      stage_en_d = '0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (ctl.start) begin
            state_d       = S_RUN;
            dwell_d       = '0;
            idx_d         = '0;
            stage_en_d    = c_stage0;
            stage_pulse_d = c_stage0;
            busy_d        = 1'b1;
            done_d        = 1'b0;
          end
        end
        S_RUN: begin
          if (dwell_q == c_dwell_last) begin
            dwell_d = '0;
            if (idx_q == c_idx_last) begin
              state_d    = S_DONE;
              stage_en_d = w_done_en;
              busy_d     = 1'b0;
              done_d     = 1'b1;
            end else begin
              idx_d         = w_idx_inc;
              stage_en_d    = w_adv_en;
              stage_pulse_d = w_next_onehot;
            end
          end else begin
            dwell_d = dwell_q + DWELL_W'(1);
          end
        end
        default: begin
          state_d    = S_IDLE;
          dwell_d    = '0;
          idx_d      = '0;
          stage_en_d = '0;
          busy_d     = 1'b0;
          done_d     = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      dwell_q       <= '0;
      idx_q         <= '0;
      stage_en_q    <= '0;
      stage_pulse_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      dwell_q       <= dwell_d;
      idx_q         <= idx_d;
      stage_en_q    <= stage_en_d;
      stage_pulse_q <= stage_pulse_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign ctl.stage_en    = stage_en_q;
  assign ctl.stage_pulse = stage_pulse_q;
  assign ctl.stage_idx   = idx_q;
  assign ctl.busy        = busy_q;
  assign ctl.done        = done_q;

endmodule
`default_nettype wire
